// File: rtl/matmul_sequencer.sv
// rtl/matmul_sequencer.sv - control FSM for the 8x8 signed matrix-multiply datapath
// Generates RAM A/B read addresses, MAC strobes, RAM C writes, done and a busy-cycle count.
module matmul_sequencer #(
   parameter int CNT_W = 11
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [5:0]       addrA1,
   output logic [5:0]       addrA2,
   output logic [5:0]       addrB,
   output logic             macc_en,
   output logic             macc_clear,
   output logic [5:0]       addrC,
   output logic             mwrC,
   output logic             c_sel,
   output logic             done,
   output logic [CNT_W-1:0] clock_count,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_MAC   = 3'd1,
      S_DRAIN = 3'd2,
      S_WR1   = 3'd3,
      S_WR2   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t     cur, nxt;
   logic [2:0] k, nk;
   logic [2:0] i, ni;
   logic [1:0] p, np;
   logic       cnt_clr;
   logic       busy;

   assign state = cur;
   assign busy  = (cur == S_MAC) || (cur == S_DRAIN) || (cur == S_WR1) || (cur == S_WR2);

   always_comb begin
      nxt     = cur;
      nk      = k;
      np      = p;
      ni      = i;
      cnt_clr = 1'b0;
      case (cur)
         S_IDLE, S_DONE: begin
            if (start) begin
               nxt     = S_MAC;
               nk      = 3'd0;
               np      = 2'd0;
               ni      = 3'd0;
               cnt_clr = 1'b1;
            end
         end
         S_MAC: begin
            nk = k + 3'd1;
            if (k == 3'd7) nxt = S_DRAIN;
         end
         S_DRAIN: nxt = S_WR1;
         S_WR1:   nxt = S_WR2;
         S_WR2: begin
            np = p + 2'd1;
            if (p == 2'd3) ni = i + 3'd1;
            nxt = (i == 3'd7 && p == 2'd3) ? S_DONE : S_MAC;
         end
         default: nxt = S_IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the state they describe.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur         <= S_IDLE;
         k           <= 3'd0;
         p           <= 2'd0;
         i           <= 3'd0;
         clock_count <= '0;
         done        <= 1'b0;
         macc_en     <= 1'b0;
         macc_clear  <= 1'b0;
         mwrC        <= 1'b0;
         c_sel       <= 1'b0;
         addrA1      <= 6'd0;
         addrA2      <= 6'd0;
         addrB       <= 6'd0;
         addrC       <= 6'd0;
      end else begin
         cur <= nxt;
         k   <= nk;
         p   <= np;
         i   <= ni;
         if (cnt_clr)
            clock_count <= '0;
         else if (busy && clock_count != {CNT_W{1'b1}})
            clock_count <= clock_count + CNT_W'(1);
         macc_en    <= (cur == S_MAC);
         macc_clear <= (cur == S_MAC) && (k == 3'd0);
         addrA1     <= (nxt == S_MAC) ? {nk, np, 1'b0} : 6'd0;
         addrA2     <= (nxt == S_MAC) ? {nk, np, 1'b1} : 6'd0;
         addrB      <= (nxt == S_MAC) ? {ni, nk} : 6'd0;
         mwrC       <= (nxt == S_WR1) || (nxt == S_WR2);
         c_sel      <= (nxt == S_WR2);
         addrC      <= (nxt == S_WR1) ? {ni, np, 1'b0} :
                       (nxt == S_WR2) ? {ni, np, 1'b1} : 6'd0;
         done       <= (nxt == S_DONE);
      end
   end

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb/tb_matmul_sequencer.sv - self-checking bench for matmul_sequencer
// Schedule model derived from the cycle index of a run, plus RAM/MAC datapath model.
module tb_matmul_sequencer;

   localparam int CNT_W = 11;
   localparam int RUN   = 352;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             start = 1'b0;
   logic             clr = 1'b0;
   logic [5:0]       addrA1, addrA2, addrB, addrC;
   logic             macc_en, macc_clear, mwrC, c_sel, done;
   logic [CNT_W-1:0] clock_count;
   logic [2:0]       state;

   matmul_sequencer #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .start(start),
      .addrA1(addrA1), .addrA2(addrA2), .addrB(addrB),
      .macc_en(macc_en), .macc_clear(macc_clear),
      .addrC(addrC), .mwrC(mwrC), .c_sel(c_sel),
      .done(done), .clock_count(clock_count), .state(state)
   );

   always #5 clk = ~clk;

   int ram_a [64];
   int ram_b [64];
   int ram_c [64];
   int wr_hits [64];
   int rd_a1, rd_a2, rd_b, acc1, acc2;
   int wr_count;
   int mt = -1;
   int checks = 0;
   int passed = 0;
   int prints = 0;
   int tr_a1 [11];
   int tr_a2 [11];
   int tr_b [11];
   int tr_clr [11];
   int tr_wr [11];
   int tr_c [11];
   logic [42:0] act_vec, exp_vec;

   // Datapath around the sequencer: 1-cycle read RAMs, two MACs, RAM C.
   always @(posedge clk) begin
      rd_a1 <= ram_a[addrA1];
      rd_a2 <= ram_a[addrA2];
      rd_b  <= ram_b[addrB];
      if (macc_en) begin
         acc1 <= macc_clear ? rd_a1 * rd_b : acc1 + rd_a1 * rd_b;
         acc2 <= macc_clear ? rd_a2 * rd_b : acc2 + rd_a2 * rd_b;
      end
      if (clr) begin
         wr_count <= 0;
         for (int e = 0; e < 64; e++) begin
            ram_c[e]   <= 999999;
            wr_hits[e] <= 0;
         end
      end else if (mwrC) begin
         ram_c[addrC]   <= c_sel ? acc2 : acc1;
         wr_hits[addrC] <= wr_hits[addrC] + 1;
         wr_count       <= wr_count + 1;
      end
   end

   // mt: -1 idle, 0..351 busy cycle index, 352 done
   always @(posedge clk or negedge reset) begin
      if (!reset)
         mt <= -1;
      else if ((mt == -1 || mt == RUN) && start)
         mt <= 0;
      else if (mt >= 0 && mt < RUN)
         mt <= mt + 1;
   end

   function automatic logic [42:0] expect_vec(input int t);
      int c, pair, pi, ii, a1, a2, b, ac, cnt;
      logic [2:0] st;
      logic en, cl, wr, sel, dn;
      a1 = 0; a2 = 0; b = 0; ac = 0; cnt = 0;
      en = 0; cl = 0; wr = 0; sel = 0; dn = 0; st = 3'd0;
      if (t >= RUN) begin
         st = 3'd5; dn = 1'b1; cnt = RUN;
      end else if (t >= 0) begin
         pair = t / 11; c = t % 11; ii = pair / 4; pi = pair % 4; cnt = t;
         if (c < 8) begin
            st = 3'd1; a1 = 8 * c + 2 * pi; a2 = a1 + 1; b = 8 * ii + c;
         end else if (c == 8) st = 3'd2;
         else if (c == 9) st = 3'd3;
         else st = 3'd4;
         en  = (c >= 1 && c <= 8);
         cl  = (c == 1);
         wr  = (c == 9 || c == 10);
         sel = (c == 10);
         if (wr) ac = 8 * ii + 2 * pi + (sel ? 1 : 0);
      end
      return {st, 6'(a1), 6'(a2), 6'(b), en, cl, 6'(ac), wr, sel, dn, 11'(cnt)};
   endfunction

   always @(negedge clk) begin
      act_vec = {state, addrA1, addrA2, addrB, macc_en, macc_clear, addrC, mwrC, c_sel, done, clock_count};
      exp_vec = expect_vec(mt);
      checks++;
      if (act_vec === exp_vec)
         passed++;
      else begin
         if (prints < 20)
            $display("FAIL cycle_outputs t=%0d actual=%h required=%h", mt, act_vec, exp_vec);
         prints++;
      end
      if (mt >= 0 && mt < 11) begin
         tr_a1[mt] = addrA1; tr_a2[mt] = addrA2; tr_b[mt] = addrB;
         tr_clr[mt] = macc_clear; tr_wr[mt] = mwrC; tr_c[mt] = addrC;
      end
   end

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act == req) passed++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, req);
   endtask

   task automatic start_run();
      @(negedge clk); start = 1'b1; clr = 1'b1;
      @(negedge clk); start = 1'b0; clr = 1'b0;
   endtask

   task automatic pulse_start_only();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_mt(input int target);
      int n = 0;
      while (mt != target && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("wait_reach", mt, target);
   endtask

   task automatic check_c(input string tag);
      int sum, good, once;
      good = 0; once = 0;
      for (int ci = 0; ci < 8; ci++)
         for (int j = 0; j < 8; j++) begin
            sum = 0;
            for (int kk = 0; kk < 8; kk++) sum += ram_a[j + 8 * kk] * ram_b[kk + 8 * ci];
            if (ram_c[j + 8 * ci] == sum) good++;
            else if (good + 1 > 0 && prints < 20) begin
               $display("FAIL %s_c[%0d] actual=%0d required=%0d", tag, j + 8 * ci, ram_c[j + 8 * ci], sum);
               prints++;
            end
         end
      check({tag, "_c_entries"}, good, 64);
      check({tag, "_writes"}, wr_count, 64);
      for (int e = 0; e < 64; e++) if (wr_hits[e] == 1) once++;
      check({tag, "_addr_once"}, once, 64);
   endtask

   task automatic fill_random();
      for (int e = 0; e < 64; e++) begin
         ram_a[e] = int'($urandom_range(255)) - 128;
         ram_b[e] = int'($urandom_range(255)) - 128;
      end
   endtask

   initial begin
      int n;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_state", state, 0);
      check("idle_done", done, 0);
      check("idle_count", clock_count, 0);

      for (int e = 0; e < 64; e++) begin
         ram_a[e] = (e % 9 == 0) ? 1 : 0;
         ram_b[e] = (e % 9 == 0) ? 1 : 0;
      end
      start_run();
      wait_mt(RUN);
      check("id_count", clock_count, 352);
      check("id_done", done, 1);
      check_c("ident");
      n = 0;
      for (int e = 0; e < 64; e++) if (ram_c[e] == ((e % 9 == 0) ? 1 : 0)) n++;
      check("ident_literal", n, 64);

      for (int e = 0; e < 64; e++) begin
         ram_a[e] = -128;
         ram_b[e] = -128;
      end
      start_run();
      wait_mt(RUN);
      check_c("neg");
      n = 0;
      for (int e = 0; e < 64; e++) if (ram_c[e] == 131072) n++;
      check("neg_literal", n, 64);
      n = 0;
      for (int kk = 0; kk < 8; kk++)
         if (tr_a1[kk] == 8 * kk && tr_a2[kk] == 8 * kk + 1 && tr_b[kk] == kk) n++;
      check("pair0_addr", n, 8);
      n = 0;
      for (int c = 0; c < 11; c++) n += tr_clr[c];
      check("pair0_clear_count", n, 1);
      check("pair0_clear_cycle2", tr_clr[1], 1);
      check("pair0_wr1", tr_wr[9] * 100 + tr_c[9], 100);
      check("pair0_wr2", tr_wr[10] * 100 + tr_c[10], 101);

      fill_random();
      start_run();
      wait_mt(5 * 11 + 3);
      pulse_start_only();
      wait_mt(RUN);
      check("midstart_count", clock_count, 352);
      check_c("rand");
      start_run();
      check("restart_done", done, 0);
      check("restart_count", clock_count, 0);
      wait_mt(10 * 11 + 9);
      #2 reset = 1'b0;
      #1;
      check("abort_mwrC", mwrC, 0);
      check("abort_state", state, 0);
      check("abort_count", clock_count, 0);
      @(negedge clk);
      check("abort_writes", wr_count, 20);
      reset = 1'b1;
      fill_random();
      start_run();
      wait_mt(RUN);
      check("after_abort_count", clock_count, 352);
      check_c("rerun");

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
